// File: rtl/axis_header_inserter_v2_if.sv
// axis_header_inserter_v2_if
// Groups the three AXI-Stream style channels of the header inserter:
//   payload in  : valid_in, data_in, keep_in, last_in / ready_in
//   stream out  : valid_out, data_out, keep_out, last_out / ready_out
//   header in   : valid_insert, data_insert, keep_insert, byte_insert_cnt / ready_insert
// Modports:
//   slave  - the inserter itself (consumes payload/header, produces the output stream)
//   master - the environment around it (source of payload/header, sink of the output)
interface axis_header_inserter_v2_if #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
);
   logic                    valid_in;
   logic [DATA_WD-1:0]      data_in;
   logic [DATA_BYTE_WD-1:0] keep_in;
   logic                    last_in;
   logic                    ready_in;

   logic                    valid_out;
   logic [DATA_WD-1:0]      data_out;
   logic [DATA_BYTE_WD-1:0] keep_out;
   logic                    last_out;
   logic                    ready_out;

   logic                    valid_insert;
   logic [DATA_WD-1:0]      data_insert;
   logic [DATA_BYTE_WD-1:0] keep_insert;
   logic [BYTE_CNT_WD-1:0]  byte_insert_cnt;
   logic                    ready_insert;

   modport slave (
      input  valid_in, data_in, keep_in, last_in,
      output ready_in,
      output valid_out, data_out, keep_out, last_out,
      input  ready_out,
      input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
      output ready_insert
   );

   modport master (
      output valid_in, data_in, keep_in, last_in,
      input  ready_in,
      input  valid_out, data_out, keep_out, last_out,
      output ready_out,
      output valid_insert, data_insert, keep_insert, byte_insert_cnt,
      input  ready_insert
   );
endinterface

// File: rtl/axis_header_inserter_v2.sv
// axis_header_inserter_v2
// Prepends 0..DATA_BYTE_WD header bytes to every AXI-Stream packet and
// re-aligns the payload across the header boundary at one beat per clock.
// A single extra flush beat is emitted only when the residual bytes of the
// last payload beat do not fit in the last output beat. Byte order is
// MSB-first (byte 0 lives in bits [DATA_WD-1 -: 8]).
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - axis_header_inserter_v2_if.slave (payload in, header in, stream out)
//   pkt_cnt / byte_cnt - statistics outputs, present only when the macro
//                        AXIS_HDR_STATS_EN is defined
module axis_header_inserter_v2 #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
   input logic                     clk,
   input logic                     rst_n,
   axis_header_inserter_v2_if.slave bus
`ifdef AXIS_HDR_STATS_EN
   ,
   output logic [31:0]             pkt_cnt,
   output logic [31:0]             byte_cnt
`endif
);

   localparam int N = DATA_BYTE_WD;
   localparam logic [BYTE_CNT_WD-1:0] N_CNT = BYTE_CNT_WD'(N);
   localparam logic [BYTE_CNT_WD:0]   N_SUM = (BYTE_CNT_WD + 1)'(N);

   typedef enum logic [1:0] {S_HDR, S_BODY, S_FLUSH} state_t;

   state_t                 state_q, state_d;
   logic [BYTE_CNT_WD-1:0] n_q;
   logic [BYTE_CNT_WD-1:0] spill_q;
   logic [DATA_WD-1:0]     resid_q;

   logic                   can_load;
   logic                   hdr_hs, body_hs, flush_ld;
   logic [BYTE_CNT_WD-1:0] n_hdr;
   logic [BYTE_CNT_WD-1:0] k_in;
   logic [BYTE_CNT_WD:0]   sum;
   logic [BYTE_CNT_WD:0]   spill_w;
   logic [2*DATA_WD-1:0]   cat_shift;
   logic [DATA_WD-1:0]     body_data;
   logic [N-1:0]           body_keep;
   logic                   body_last;
   logic [BYTE_CNT_WD-1:0] flush_sh;
   logic [N-1:0]           flush_keep;
   logic [DATA_WD-1:0]     flush_data;
   logic                   unused_keep_insert;

   function automatic logic [BYTE_CNT_WD-1:0] popCount(input logic [N-1:0] keep);
      logic [BYTE_CNT_WD-1:0] c;
      c = '0;
      for (int i = 0; i < N; i++) begin
         c = c + BYTE_CNT_WD'(keep[i]);
      end
      return c;
   endfunction

   // top m bits set in an N-bit keep vector; m == N gives all ones
   function automatic logic [N-1:0] topOnes(input logic [BYTE_CNT_WD:0] m);
      return ~({N{1'b1}} >> m);
   endfunction

   function automatic logic [DATA_WD-1:0] keepMask(input logic [N-1:0] keep);
      logic [DATA_WD-1:0] m;
      for (int i = 0; i < N; i++) begin
         m[i*8 +: 8] = {8{keep[i]}};
      end
      return m;
   endfunction

   // low n bytes set; n == N shifts everything out and yields all ones
   function automatic logic [DATA_WD-1:0] lowMask(input logic [BYTE_CNT_WD-1:0] n);
      return ~({DATA_WD{1'b1}} << {n, 3'b000});
   endfunction

   // keep_insert is informational only; byte_insert_cnt decides the header length
   assign unused_keep_insert = ^bus.keep_insert;

   assign can_load = ~bus.valid_out | bus.ready_out;
   assign n_hdr    = (bus.byte_insert_cnt > N_CNT) ? N_CNT : bus.byte_insert_cnt;
   assign k_in     = popCount(bus.keep_in);
   assign sum      = {1'b0, n_q} + {1'b0, k_in};
   assign spill_w  = sum - N_SUM;

   // Body beat: the n residual bytes followed by the top N-n payload bytes,
   // taken from the low word of the 2-word concatenation shifted by n bytes.
   assign cat_shift = {resid_q, bus.data_in} >> {n_q, 3'b000};
   assign body_last = bus.last_in && (sum <= N_SUM);
   assign body_keep = body_last ? topOnes(sum) : {N{1'b1}};
   assign body_data = cat_shift[DATA_WD-1:0] & keepMask(body_keep);

   // Flush beat: residual moved up to the MSB end, only the spilled bytes kept
   assign flush_sh   = N_CNT - n_q;
   assign flush_keep = topOnes({1'b0, spill_q});
   assign flush_data = (resid_q << {flush_sh, 3'b000}) & keepMask(flush_keep);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_HDR;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and channel ready signals; every channel only moves when the
   // output register can take a new beat
   always_comb begin
      state_d          = state_q;
      bus.ready_in     = 1'b0;
      bus.ready_insert = 1'b0;
      hdr_hs           = 1'b0;
      body_hs          = 1'b0;
      flush_ld         = 1'b0;
      case (state_q)
         S_HDR: begin
            bus.ready_insert = can_load;
            if (bus.valid_insert && can_load) begin
               hdr_hs  = 1'b1;
               state_d = S_BODY;
            end
         end
         S_BODY: begin
            bus.ready_in = can_load;
            if (bus.valid_in && can_load) begin
               body_hs = 1'b1;
               if (bus.last_in) begin
                  state_d = (sum > N_SUM) ? S_FLUSH : S_HDR;
               end
            end
         end
         S_FLUSH: begin
            if (can_load) begin
               flush_ld = 1'b1;
               state_d  = S_HDR;
            end
         end
         default: state_d = S_HDR;
      endcase
   end

   // Residual bytes, header length and the registered output beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_q           <= '0;
         spill_q       <= '0;
         resid_q       <= '0;
         bus.valid_out <= 1'b0;
         bus.data_out  <= '0;
         bus.keep_out  <= '0;
         bus.last_out  <= 1'b0;
      end else begin
         if (hdr_hs) begin
            n_q     <= n_hdr;
            resid_q <= bus.data_insert & lowMask(n_hdr);
         end
         if (body_hs) begin
            resid_q <= bus.data_in & lowMask(n_q);
            spill_q <= spill_w[BYTE_CNT_WD-1:0];
         end
         if (body_hs) begin
            bus.valid_out <= 1'b1;
            bus.data_out  <= body_data;
            bus.keep_out  <= body_keep;
            bus.last_out  <= body_last;
         end else if (flush_ld) begin
            bus.valid_out <= 1'b1;
            bus.data_out  <= flush_data;
            bus.keep_out  <= flush_keep;
            bus.last_out  <= 1'b1;
         end else if (bus.ready_out) begin
            bus.valid_out <= 1'b0;
         end
      end
   end

`ifdef AXIS_HDR_STATS_EN
   // Packet and byte counters, counted on output handshakes, wrapping at 2^32
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt  <= '0;
         byte_cnt <= '0;
      end else if (bus.valid_out && bus.ready_out) begin
         byte_cnt <= byte_cnt + 32'(popCount(bus.keep_out));
         if (bus.last_out) begin
            pkt_cnt <= pkt_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_axis_header_inserter_v2.sv
// tb_axis_header_inserter_v2
// Scoreboard bench: each packet is turned into the expected output beats by
// concatenating header bytes and payload bytes and cutting the byte stream
// into DATA_BYTE_WD-byte beats. A negedge monitor pops and compares every
// output beat that is handshaked. Build with +define+AXIS_HDR_STATS_EN to
// also check the statistics counters.
module tb_axis_header_inserter_v2;

   localparam int DATA_WD = 32;
   localparam int N       = DATA_WD / 8;

   typedef struct packed {
      logic [DATA_WD-1:0] data;
      logic [N-1:0]       keep;
      logic               last;
   } beat_t;

   logic clk;
   logic rst_n;

   axis_header_inserter_v2_if #(.DATA_WD(DATA_WD)) bus ();

`ifdef AXIS_HDR_STATS_EN
   logic [31:0] pkt_cnt;
   logic [31:0] byte_cnt;
`endif

   axis_header_inserter_v2 #(.DATA_WD(DATA_WD)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus)
`ifdef AXIS_HDR_STATS_EN
      ,
      .pkt_cnt  (pkt_cnt),
      .byte_cnt (byte_cnt)
`endif
   );

   beat_t      exp_q[$];
   logic [7:0] pay_q[$];
   int         compared   = 0;
   int         mismatched = 0;
   int         exp_pkts   = 0;
   int         exp_bytes  = 0;
   int         ready_mode = 1;

   // Clock generation
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Downstream ready: 0 = stalled, 1 = always ready, otherwise random 50%
   initial begin
      bus.ready_out = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.ready_out = 1'b0;
            1:       bus.ready_out = 1'b1;
            default: bus.ready_out = 1'($urandom % 2);
         endcase
      end
   end

   task automatic printSummary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic reportFail(input string name);
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: actual=timeout/unexpected required=handshake/expected", name);
   endtask

   // Monitor: a beat is transferred at the next rising edge when valid and ready
   // are both high at the falling edge
   always @(negedge clk) begin
      if (rst_n && bus.valid_out && bus.ready_out) begin
         if (exp_q.size() == 0) begin
            reportFail("unexpected_output_beat");
         end else begin
            beat_t e;
            beat_t a;
            e = exp_q.pop_front();
            a = '{data: bus.data_out, keep: bus.keep_out, last: bus.last_out};
            checkOutput("output_beat", 64'(a), 64'(e));
            if (e.last) exp_pkts++;
            exp_bytes += $countones(e.keep);
         end
      end
   end

   // Waits for a handshake on the header (is_hdr=1) or payload channel
   task automatic waitHs(input bit is_hdr);
      int cyc;
      bit hs;
      cyc = 0;
      forever begin
         @(negedge clk);
         hs = is_hdr ? bus.ready_insert : bus.ready_in;
         @(posedge clk);
         #1;
         if (hs) break;
         cyc++;
         if (cyc > 2000) begin
            reportFail(is_hdr ? "header_handshake_timeout" : "payload_handshake_timeout");
            printSummary();
            $finish;
         end
      end
   endtask

   // Sends one packet (header cnt/hdr, payload bytes in pay_q) and pushes the
   // expected output beats
   task automatic applyStimulus(input int cnt, input logic [31:0] hdr, input bit gaps);
      logic [7:0] s[$];
      beat_t      b;
      int         n;
      int         len;
      n   = (cnt > N) ? N : cnt;
      len = pay_q.size();
      for (int j = 0; j < n; j++) s.push_back(hdr[(n-1-j)*8 +: 8]);
      foreach (pay_q[i]) s.push_back(pay_q[i]);
      while (s.size() > 0) begin
         b = '0;
         for (int i = 0; i < N; i++) begin
            if (s.size() > 0) begin
               b.data[(N-1-i)*8 +: 8] = s.pop_front();
               b.keep[N-1-i]          = 1'b1;
            end
         end
         b.last = (s.size() == 0);
         exp_q.push_back(b);
      end

      bus.valid_insert    = 1'b1;
      bus.data_insert     = hdr;
      bus.byte_insert_cnt = 3'(cnt);
      bus.keep_insert     = 4'($urandom);
      waitHs(1'b1);
      bus.valid_insert = 1'b0;
      bus.data_insert  = $urandom;

      for (int base = 0; base < len; base += N) begin
         if (gaps && ($urandom % 4 == 0)) begin
            bus.valid_in = 1'b0;
            @(posedge clk);
            #1;
         end
         for (int i = 0; i < N; i++) begin
            if (base + i < len) begin
               bus.data_in[(N-1-i)*8 +: 8] = pay_q[base+i];
               bus.keep_in[N-1-i]          = 1'b1;
            end else begin
               bus.data_in[(N-1-i)*8 +: 8] = 8'($urandom);
               bus.keep_in[N-1-i]          = 1'b0;
            end
         end
         bus.last_in  = (base + N >= len);
         bus.valid_in = 1'b1;
         waitHs(1'b0);
      end
      bus.valid_in = 1'b0;
      bus.last_in  = 1'b0;
   endtask

   task automatic drain();
      int cyc;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 3000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic checkResetValues();
      checkOutput("rst_valid_out", 64'(bus.valid_out), 64'd0);
      checkOutput("rst_last_out", 64'(bus.last_out), 64'd0);
      checkOutput("rst_data_out", 64'(bus.data_out), 64'd0);
      checkOutput("rst_keep_out", 64'(bus.keep_out), 64'd0);
      checkOutput("rst_ready_in", 64'(bus.ready_in), 64'd0);
      checkOutput("rst_ready_insert", 64'(bus.ready_insert), 64'd1);
`ifdef AXIS_HDR_STATS_EN
      checkOutput("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
      checkOutput("rst_byte_cnt", 64'(byte_cnt), 64'd0);
`endif
   endtask

   task automatic checkStats();
`ifdef AXIS_HDR_STATS_EN
      checkOutput("pkt_cnt", 64'(pkt_cnt), 64'(exp_pkts));
      checkOutput("byte_cnt", 64'(byte_cnt), 64'(exp_bytes));
`endif
   endtask

   // Global watchdog
   initial begin
      #800000;
      reportFail("global_watchdog");
      printSummary();
      $finish;
   end

   // Main sequence
   initial begin
      int len;
      rst_n               = 1'b0;
      bus.valid_in        = 1'b0;
      bus.data_in         = '0;
      bus.keep_in         = '0;
      bus.last_in         = 1'b0;
      bus.valid_insert    = 1'b0;
      bus.data_insert     = '0;
      bus.keep_insert     = '0;
      bus.byte_insert_cnt = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetValues();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] directed packets");
      pay_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
      applyStimulus(2, 32'h0000_AABB, 1'b0);
      pay_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      applyStimulus(2, 32'h0000_CAFE, 1'b0);
      pay_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h31};
      applyStimulus(0, 32'hFFFF_FFFF, 1'b0);
      pay_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      applyStimulus(4, 32'h0102_0304, 1'b0);
      drain();

      $display("[TB] random packets with random back-pressure");
      ready_mode = 2;
      for (int p = 0; p < 100; p++) begin
         len = int'($urandom_range(1, 16));
         pay_q.delete();
         for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom));
         applyStimulus(int'($urandom_range(0, 7)), $urandom, 1'b1);
      end
      drain();
      checkStats();

      $display("[TB] reset in the middle of a packet");
      ready_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      bus.valid_insert    = 1'b1;
      bus.data_insert     = 32'h0000_1234;
      bus.byte_insert_cnt = 3'd2;
      waitHs(1'b1);
      bus.valid_insert = 1'b0;
      bus.data_in      = 32'h5566_7788;
      bus.keep_in      = 4'b1111;
      bus.last_in      = 1'b0;
      bus.valid_in     = 1'b1;
      waitHs(1'b0);
      bus.valid_in = 1'b0;
      @(negedge clk);
      checkOutput("held_beat_before_reset", 64'(bus.valid_out), 64'd1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkResetValues();
      exp_pkts  = 0;
      exp_bytes = 0;
      @(posedge clk);
      #1;
      rst_n      = 1'b1;
      ready_mode = 1;
      @(posedge clk);
      #1;
      pay_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
      applyStimulus(3, 32'h00D0_D1D2, 1'b0);
      drain();
      checkStats();

      printSummary();
      $finish;
   end

endmodule
